// File: rtl/paddle_array.sv
// paddle_array: N vertical paddles overlaid on a 26-bit pixel stream.
// Stream layout: [25] hsync, [24] vsync, [23] active video, [22:13] x, [12:3] y, [2:0] rgb.
// Each paddle's top-y moves once per frame (on the vsync rising edge) from its
// up/down buttons, clamped to [POS_MIN, POS_MAX]. The draw stage is one register deep.
module paddle_array #(
  parameter int unsigned NUM_PLY = 2,
  parameter int unsigned PLY_W   = 10,
  parameter int unsigned PLY_H   = 64,
  parameter int unsigned X_FIRST = 20,
  parameter int unsigned X_STEP  = 750,
  parameter int unsigned SPEED   = 4,
  parameter int unsigned POS_MIN = 0,
  parameter int unsigned POS_MAX = 416,
  parameter logic [2:0]  PLY_RGB = 3'b111
) (
  input  logic                   px_clk,
  input  logic                   reset,
  input  logic [25:0]            strRGB_i,
  input  logic [NUM_PLY-1:0]     btn_up,
  input  logic [NUM_PLY-1:0]     btn_down,
  output logic [NUM_PLY*10-1:0]  pos_o,
  output logic [25:0]            strRGB_o
);

  // All position and draw arithmetic is 11 bits wide so that pos + SPEED and
  // pos + PLY_H - 1 never wrap for legal 10-bit positions.
  localparam logic [10:0] PosMin       = 11'(POS_MIN);
  localparam logic [10:0] PosMax       = 11'(POS_MAX);
  localparam logic [10:0] Speed        = 11'(SPEED);
  localparam logic [10:0] MinPlusSpeed = 11'(POS_MIN + SPEED);
  localparam logic [10:0] PlyHm1       = 11'(PLY_H - 1);
  localparam logic [9:0]  PosMin10     = 10'(POS_MIN);
  localparam logic [9:0]  PosMax10     = 10'(POS_MAX);
  localparam logic [9:0]  PosInit10    = 10'((POS_MIN + POS_MAX) / 2);

  // Stream fields
  logic        vs_in;
  logic        av_in;
  logic [10:0] x_in;
  logic [10:0] y_in;

  assign vs_in = strRGB_i[24];
  assign av_in = strRGB_i[23];
  assign x_in  = {1'b0, strRGB_i[22:13]};
  assign y_in  = {1'b0, strRGB_i[12:3]};

  // Frame tick: one cycle at the vsync rising edge.
  logic vs_q;
  logic tick;

  assign tick = vs_in & ~vs_q;

  // Registers the previous vsync level for edge detection.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      vs_q <= 1'b0;
    end else begin
      vs_q <= vs_in;
    end
  end

  logic [NUM_PLY-1:0] hit;

  for (genvar k = 0; k < NUM_PLY; k++) begin : g_ply
    // Left edge is fixed at elaboration. A paddle whose box does not fit in the
    // 11-bit compare range lies beyond any reachable x and is simply never drawn.
    localparam int unsigned XlInt   = X_FIRST + k * X_STEP;
    localparam int unsigned XhInt   = XlInt + PLY_W - 1;
    localparam bit          InRange = (XhInt < 2048);
    localparam logic [10:0] XLo     = 11'(XlInt);
    localparam logic [10:0] XHi     = 11'(XhInt);

    logic [9:0]  pos_q;
    logic [9:0]  pos_d;
    logic [10:0] pos_ext;
    logic        go_up;
    logic        go_down;

    assign pos_ext = {1'b0, pos_q};
    assign go_up   = tick & btn_up[k] & ~btn_down[k];
    assign go_down = tick & btn_down[k] & ~btn_up[k];

    // Next position: saturating step on the tick, hold otherwise.
    always_comb begin
      pos_d = pos_q;
      if (go_up) begin
        if (pos_ext < MinPlusSpeed) begin
          pos_d = PosMin10;
        end else begin
          pos_d = 10'(pos_ext - Speed);
        end
      end else if (go_down) begin
        if ((pos_ext + Speed) > PosMax) begin
          pos_d = PosMax10;
        end else begin
          pos_d = 10'(pos_ext + Speed);
        end
      end
    end

    // Position register, recentred on reset.
    always_ff @(posedge px_clk) begin
      if (reset) begin
        pos_q <= PosInit10;
      end else begin
        pos_q <= pos_d;
      end
    end

    assign pos_o[10*k +: 10] = pos_q;

    // Box test against the current (pre-update) position; updates only happen in blanking.
    always_comb begin
      hit[k] = 1'b0;
      if (InRange && av_in) begin
        hit[k] = (x_in >= XLo) && (x_in <= XHi) &&
                 (y_in >= pos_ext) && (y_in <= (pos_ext + PlyHm1));
      end
    end
  end : g_ply

  // Overlapping paddles share a colour, so a plain OR of the hits is enough.
  logic [25:0] str_d;
  logic [25:0] str_q;

  // Overlay colour onto the stream; all other fields pass through.
  always_comb begin
    str_d = strRGB_i;
    if (|hit) begin
      str_d[2:0] = PLY_RGB;
    end
  end

  // Single output stage for all 26 bits.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      str_q <= '0;
    end else begin
      str_q <= str_d;
    end
  end

  assign strRGB_o = str_q;

  // Sanity of parameters is the integrator's concern; PosMin is kept for clarity of the clamp.
  logic unused_posmin;
  assign unused_posmin = ^PosMin;

endmodule

// File: tb/tb_paddle_array.sv
// Self-checking bench for paddle_array: default 2-paddle instance plus a
// 4-paddle, X_STEP=200, SPEED=7 instance, both fed the same stream.
module tb_paddle_array;

  logic        clk;
  logic        rst;
  logic [25:0] str_i;
  logic [1:0]  up_a, dn_a;
  logic [3:0]  up_b, dn_b;
  logic [19:0] pos_o_a;
  logic [39:0] pos_o_b;
  logic [25:0] str_o_a, str_o_b;

  paddle_array dut_a (
    .px_clk   (clk),
    .reset    (rst),
    .strRGB_i (str_i),
    .btn_up   (up_a),
    .btn_down (dn_a),
    .pos_o    (pos_o_a),
    .strRGB_o (str_o_a)
  );

  paddle_array #(
    .NUM_PLY (4),
    .X_STEP  (200),
    .SPEED   (7)
  ) dut_b (
    .px_clk   (clk),
    .reset    (rst),
    .strRGB_i (str_i),
    .btn_up   (up_b),
    .btn_down (dn_b),
    .pos_o    (pos_o_b),
    .strRGB_o (str_o_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: plain integer positions per configuration.
  int mpos [2][8];
  bit mvs;
  int cfg_n     [2] = '{2, 4};
  int cfg_xstep [2] = '{750, 200};
  int cfg_spd   [2] = '{4, 7};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int move(input int p, input logic up, input logic dn, input int spd);
    if (up && !dn) return (p - spd < 0) ? 0 : p - spd;
    if (dn && !up) return (p + spd > 416) ? 416 : p + spd;
    return p;
  endfunction

  function automatic logic [25:0] model_out(input int c, input logic [25:0] s);
    int x, y, xl;
    bit hit;
    x = int'(s[22:13]);
    y = int'(s[12:3]);
    hit = 1'b0;
    for (int k = 0; k < cfg_n[c]; k++) begin
      xl = 20 + k * cfg_xstep[c];
      if (s[23] && x >= xl && x <= xl + 9 && y >= mpos[c][k] && y <= mpos[c][k] + 63) hit = 1'b1;
    end
    return hit ? {s[25:3], 3'b111} : s;
  endfunction

  function automatic logic [63:0] model_pos(input int c);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < cfg_n[c]; k++) r[10*k +: 10] = 10'(mpos[c][k]);
    return r;
  endfunction

  // One clock: predict from current inputs and model state, step model, compare after edge.
  task automatic clk_cycle();
    logic [25:0] ea, eb;
    if (rst) begin
      ea = '0;
      eb = '0;
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 8; k++) mpos[c][k] = 208;
      mvs = 1'b0;
    end else begin
      ea = model_out(0, str_i);
      eb = model_out(1, str_i);
      if (str_i[24] && !mvs) begin
        for (int k = 0; k < 2; k++) mpos[0][k] = move(mpos[0][k], up_a[k], dn_a[k], 4);
        for (int k = 0; k < 4; k++) mpos[1][k] = move(mpos[1][k], up_b[k], dn_b[k], 7);
      end
      mvs = str_i[24];
    end
    @(posedge clk);
    #1;
    check("stream_a", 64'(str_o_a), 64'(ea));
    check("stream_b", 64'(str_o_b), 64'(eb));
    check("pos_a", 64'(pos_o_a), model_pos(0));
    check("pos_b", 64'(pos_o_b), model_pos(1));
  endtask

  function automatic logic [25:0] rnd_stream(input bit vs);
    logic [25:0] r;
    r = 26'($urandom);
    r[24] = vs;
    return r;
  endfunction

  // One blanking cycle (vsync low) then a vsync-high tick cycle with buttons held.
  task automatic frame(input logic [1:0] ua, input logic [1:0] da,
                       input logic [3:0] ub, input logic [3:0] db);
    up_a = ua; dn_a = da; up_b = ub; dn_b = db;
    str_i = rnd_stream(1'b0);
    clk_cycle();
    str_i = rnd_stream(1'b1);
    clk_cycle();
    up_a = '0; dn_a = '0; up_b = '0; dn_b = '0;
  endtask

  typedef struct {
    logic       av;
    int         x;
    int         y;
    logic [2:0] exp_rgb;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [25:0] s;
    logic [9:0]  xs;
    int          xbase [5] = '{20, 770, 220, 420, 620};

    rst = 1'b1; str_i = '0; up_a = '0; dn_a = '0; up_b = '0; dn_b = '0;

    // Reset with random stream.
    for (int i = 0; i < 3; i++) begin
      str_i = rnd_stream(1'($urandom));
      clk_cycle();
    end
    check("rst_out", 64'(str_o_a), 64'd0);
    check("rst_pos", 64'(pos_o_a), {44'd0, 10'd208, 10'd208});
    rst = 1'b0;
    s = rnd_stream(1'b0);
    str_i = s;
    clk_cycle();

    // Up with clamp at 0.
    frame(2'b01, 2'b00, 4'h0, 4'h0);
    check("up_t1", 64'(pos_o_a[9:0]), 64'd204);
    frame(2'b01, 2'b00, 4'h0, 4'h0);
    check("up_t2", 64'(pos_o_a[9:0]), 64'd200);
    frame(2'b01, 2'b00, 4'h0, 4'h0);
    check("up_t3", 64'(pos_o_a[9:0]), 64'd196);
    check("up_p1_hold", 64'(pos_o_a[19:10]), 64'd208);
    for (int i = 0; i < 60; i++) frame(2'b01, 2'b00, 4'h0, 4'h0);
    check("up_clamp", 64'(pos_o_a[9:0]), 64'd0);

    // Down with clamp at 416.
    for (int i = 0; i < 120; i++) frame(2'b00, 2'b01, 4'h0, 4'h0);
    check("down_clamp", 64'(pos_o_a[9:0]), 64'd416);
    check("down_p1_hold", 64'(pos_o_a[19:10]), 64'd208);

    // Both buttons: hold.
    for (int i = 0; i < 5; i++) frame(2'b11, 2'b11, 4'hf, 4'hf);
    check("both_hold", 64'(pos_o_a), {44'd0, 10'd208, 10'd416});

    // Buttons only between ticks: ignored.
    for (int i = 0; i < 4; i++) begin
      up_a = 2'b11; up_b = 4'hf;
      str_i = rnd_stream(1'b0);
      clk_cycle();
      up_a = '0; up_b = '0;
      str_i = rnd_stream(1'b1);
      clk_cycle();
    end
    check("pulse_hold", 64'(pos_o_a), {44'd0, 10'd208, 10'd416});

    // Bring paddle 0 to 100 for the draw boundary table.
    for (int i = 0; i < 79; i++) frame(2'b01, 2'b00, 4'h0, 4'h0);
    check("pos_100", 64'(pos_o_a[9:0]), 64'd100);

    tbl[0]  = '{1'b1,  19, 120, 3'b010};
    tbl[1]  = '{1'b1,  20, 100, 3'b111};
    tbl[2]  = '{1'b1,  29, 163, 3'b111};
    tbl[3]  = '{1'b1,  30, 120, 3'b010};
    tbl[4]  = '{1'b1,  25, 164, 3'b010};
    tbl[5]  = '{1'b1,  25,  99, 3'b010};
    tbl[6]  = '{1'b1,  25, 130, 3'b111};
    tbl[7]  = '{1'b0,  25, 130, 3'b010};
    tbl[8]  = '{1'b1, 770, 208, 3'b111};
    tbl[9]  = '{1'b1, 779, 271, 3'b111};
    tbl[10] = '{1'b1, 780, 208, 3'b010};
    tbl[11] = '{1'b1, 769, 250, 3'b010};
    tbl[12] = '{1'b1, 770, 272, 3'b010};
    for (int i = 0; i < 13; i++) begin
      str_i = {1'b0, 1'b0, tbl[i].av, 10'(tbl[i].x), 10'(tbl[i].y), 3'b010};
      clk_cycle();
      check($sformatf("draw_%0d", i), 64'(str_o_a[2:0]), 64'(tbl[i].exp_rgb));
    end

    // Four-paddle instance: clamp at 416 with SPEED=7 and independent control.
    for (int i = 0; i < 29; i++) frame(2'b00, 2'b00, 4'h0, 4'b0100);
    check("b_p2_411", 64'(pos_o_b[29:20]), 64'd411);
    frame(2'b00, 2'b00, 4'h0, 4'b0100);
    check("b_p2_416", 64'(pos_o_b[29:20]), 64'd416);
    for (int i = 0; i < 30; i++) frame(2'b00, 2'b00, 4'b0010, 4'h0);
    check("b_indep", 64'(pos_o_b), {24'd0, 10'd208, 10'd416, 10'd0, 10'd208});
    for (int i = 0; i < 3; i++) frame(2'b00, 2'b00, 4'b0001, 4'b1000);
    check("b_indep2", 64'(pos_o_b), {24'd0, 10'd229, 10'd416, 10'd0, 10'd187});

    // Reset with vsync high, then release with vsync still high: immediate tick.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      str_i = rnd_stream(1'b1);
      clk_cycle();
    end
    check("midrst_out", 64'(str_o_a), 64'd0);
    rst = 1'b0;
    dn_a = 2'b01;
    str_i = rnd_stream(1'b1);
    clk_cycle();
    check("midrst_tick", 64'(pos_o_a[9:0]), 64'd212);
    dn_a = '0;
    str_i = rnd_stream(1'b1);
    clk_cycle();
    check("midrst_once", 64'(pos_o_a[9:0]), 64'd212);

    // Random stream biased toward paddle columns, random buttons and vsync.
    for (int i = 0; i < 1500; i++) begin
      up_a = 2'($urandom); dn_a = 2'($urandom);
      up_b = 4'($urandom); dn_b = 4'($urandom);
      s = rnd_stream(($urandom_range(0, 7) == 0) ? ~str_i[24] : str_i[24]);
      xs = 10'(xbase[$urandom_range(0, 4)] + $urandom_range(0, 14) - 2);
      s[22:13] = xs;
      s[12:3]  = 10'($urandom_range(0, 479));
      if ($urandom_range(0, 3) != 0) s[23] = 1'b1;
      str_i = s;
      clk_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/paddle_array.md
Name: paddle_array

Overview:
- Parameterised successor to the two-paddle drawer.
- Owns N vertical paddles and their motion logic, and overlays them onto the pixel stream.
- Each paddle's position register is updated once per frame from per-player up/down buttons, with speed and saturation limits.
- Sits in the stream chain between the background generator and the ball/score overlays.

Parameters:
- NUM_PLY, 2: number of paddles (1..8).
- PLY_W, 10: paddle width in pixels.
- PLY_H, 64: paddle height in pixels.
- X_FIRST, 20: left x of paddle 0.
- X_STEP, 750: x pitch between paddles; paddle k left = X_FIRST + k*X_STEP.
- SPEED, 4: pixels moved per frame tick.
- POS_MIN, 0: minimum top y.
- POS_MAX, 416: maximum top y (480 - PLY_H).
- PLY_RGB, 3'b111: paddle colour.

Ports:
- px_clk  input  1  pixel clock.
- reset  input  1  synchronous, active-high reset.
- strRGB_i  input  26  stream in: [25] hsync, [24] vsync, [23] active video, [22:13] x, [12:3] y, [2:0] rgb.
- btn_up  input  NUM_PLY  per-player up request, level.
- btn_down  input  NUM_PLY  per-player down request, level.
- pos_o  output  NUM_PLY*10  packed top-y of each paddle; paddle k at [10k+9:10k].
- strRGB_o  output  26  stream out, same layout.

Behaviour:
- Single clock px_clk; reset is synchronous and active-high; all state is updated on the px_clk rising edge.
- Reset values:
  - strRGB_o = 0.
  - vs_q = 0.
  - Every pos_k = POS_INIT = (POS_MIN+POS_MAX)/2 (208 with defaults).
- Frame tick:
  - vs_q holds the registered strRGB_i[24].
  - tick = strRGB_i[24] & ~vs_q, i.e. exactly one cycle per frame.
  - Buttons are sampled only on the tick cycle; they are ignored at all other times.
- Motion on tick, per paddle k, computed in 11-bit unsigned arithmetic:
  - up=1, down=0: if pos_k < POS_MIN+SPEED then pos_k <= POS_MIN, else pos_k <= pos_k - SPEED.
  - down=1, up=0: if pos_k + SPEED > POS_MAX then pos_k <= POS_MAX, else pos_k <= pos_k + SPEED.
  - Both buttons set or neither set: hold.
  - No wrap-around is permitted under any input.
- pos_o is driven directly from the position registers; a tick updates it on the next cycle.
- Draw, one registered stage (latency exactly 1 cycle for all 26 bits):
  - hit_k = av & (x >= XL_k) & (x <= XL_k+PLY_W-1) & (y >= pos_k) & (y <= pos_k+PLY_H-1), with XL_k = X_FIRST + k*X_STEP computed at elaboration.
  - Comparisons are 11-bit.
  - If any hit_k: strRGB_o[2:0] = PLY_RGB; otherwise rgb passes through.
  - hsync, vsync, av, x and y always pass through unchanged, delayed by 1 cycle.
- Tearing: draw uses the current pos_k. Because the tick coincides with the vsync rising edge (blanking), position changes never occur during active video of a frame.
- Overlapping paddles (small X_STEP): the result is the OR of all hits, so the colour is the same.
- Paddles whose XL_k+PLY_W-1 exceeds 799 are clipped naturally by the x compare. No error is raised.
- Reset mid-frame:
  - Takes effect on the next edge: output goes to 0, positions return to POS_INIT, vs_q clears.
  - If vsync is high while reset is asserted, the first cycle after reset deassertion with vsync high produces a tick.
- RTL must be generated with a for-loop over NUM_PLY. There is no per-instance hand wiring.

Test Plan:
- Reset: assert reset 3 cycles with random stream -> strRGB_o=0, pos_o = {208,208}. First output after release equals the prior input cycle's stream.
- Motion and clamp:
  - Hold btn_up[0] for 3 vsync rising edges -> pos_0 = 208,204,200,196 after successive ticks; pos_1 stays 208.
  - Hold for 60 ticks -> pos_0 saturates at 0, never wraps to 1020+.
  - Same test for btn_down with saturation at 416.
- Simultaneous and tick-only sampling:
  - up and down both high for 5 ticks -> pos unchanged.
  - Button pulsed high only between ticks (never on the tick cycle) -> pos unchanged.
- Draw boundaries at pos_0=100, av=1:
  - (x=19,y=120) -> rgb passes through.
  - (x=20,y=100) and (x=29,y=163) -> rgb=3'b111.
  - (x=30,y=120) and (x=25,y=164) -> passes through.
  - Paddle 1 hit at x=770..779.
- Latency and blanking:
  - Random stream -> every strRGB_o equals the expected value computed from strRGB_i one cycle earlier.
  - av=0 inside a paddle box -> rgb passes through.
- Parameter sweep: NUM_PLY=4, X_STEP=200, SPEED=7 -> paddles at x=20,220,420,620.
  - From 208, down for 30 ticks -> 416 after clamp (208+7*29=411, then 416).
  - Independent control per player.
